// File: rtl/sipo_reg.sv
// Serial-in, parallel-out shift register with parameterised shift direction.
// Shifts on every rising clock; asynchronous active-high reset to RESET_VALUE.
module sipo_reg #(
    parameter int                 WIDTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter bit                 MSB_FIRST   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             si,
    output logic [WIDTH-1:0] po
);

    logic [WIDTH-1:0] shifted;

    // New bit enters at the low end for MSB_FIRST, at the high end otherwise
    if (MSB_FIRST) begin : g_msb_first
        assign shifted = {po[WIDTH-2:0], si};
    end else begin : g_lsb_first
        assign shifted = {si, po[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            po <= RESET_VALUE;
        end else begin
            po <= shifted;
        end
    end

endmodule

// File: tb/tb_sipo_reg.sv
// Bench for sipo_reg: directed vectors on the default instance plus a
// bit-history model compared every cycle on both default and LSB-first instances.
module tb_sipo_reg;

    localparam int        WA = 4;
    localparam logic [3:0] RA = 4'h0;
    localparam int        WB = 8;
    localparam logic [7:0] RB = 8'hA5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          si = 1'b0;
    logic [WA-1:0] po;
    logic          reset_b = 1'b0;
    logic          si_b = 1'b0;
    logic [WB-1:0] po_b;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sipo_reg #(.WIDTH(WA), .RESET_VALUE(RA), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .si(si), .po(po)
    );

    sipo_reg #(.WIDTH(WB), .RESET_VALUE(RB), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .si(si_b), .po(po_b)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: history of bits in arrival order (oldest first), seeded with reset value
    bit qa[$];
    bit qb[$];

    function automatic logic [WA-1:0] model_a();
        logic [WA-1:0] v;
        v = '0;
        for (int i = 0; i < WA; i++) v[i] = qa[WA-1-i];
        return v;
    endfunction

    function automatic logic [WB-1:0] model_b();
        logic [WB-1:0] v;
        v = '0;
        for (int i = 0; i < WB; i++) v[i] = qb[i];
        return v;
    endfunction

    task automatic seed_a();
        qa.delete();
        for (int i = WA - 1; i >= 0; i--) qa.push_back(RA[i]);
    endtask

    task automatic seed_b();
        qb.delete();
        for (int i = 0; i < WB; i++) qb.push_back(RB[i]);
    endtask

    initial begin
        seed_a();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                seed_a();
            end else begin
                qa.push_back(si);
                void'(qa.pop_front());
            end
            #1;
            check("model_a", 32'(po), 32'(model_a()));
        end
    end

    initial begin
        seed_b();
        forever begin
            @(posedge clk or posedge reset_b);
            if (reset_b) begin
                seed_b();
            end else begin
                qb.push_back(si_b);
                void'(qb.pop_front());
            end
            #1;
            check("model_b", 32'(po_b), 32'(model_b()));
        end
    end

    logic [3:0] seq_si;
    logic [3:0] seq_po [7];
    logic [3:0] pat_si;

    initial begin
        seq_si = 4'b0;
        seq_po = '{4'b0001, 4'b0010, 4'b0101, 4'b1011,
                   4'b0111, 4'b1110, 4'b1100};

        #1 reset = 1'b1;
        reset_b = 1'b1;
        #1;
        check("reset_before_edge", 32'(po), 32'h0);
        check("reset_b_value", 32'(po_b), 32'hA5);

        @(posedge clk) #1;
        check("reset_hold_5ns", 32'(po), 32'h0);
        @(posedge clk) #1;
        check("reset_hold_15ns", 32'(po), 32'h0);

        @(negedge clk);
        reset = 1'b0;
        si = 1'b0;
        @(posedge clk) #1;
        check("release_no_shift", 32'(po), 32'h0);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            si = (i == 0 || i == 2 || i == 3 || i == 4);
            @(posedge clk) #1;
            check($sformatf("seq_%0d", i), 32'(po), 32'(seq_po[i]));
        end

        pat_si = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            si = pat_si[i];
            @(posedge clk);
        end
        #1;
        check("pre_pulse_1011", 32'(po), 32'hB);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_pulse", 32'(po), 32'h0);
        #2;
        reset = 1'b0;
        si = 1'b1;
        @(posedge clk) #1;
        check("after_pulse_1", 32'(po), 32'h1);
        @(posedge clk) #1;
        check("after_pulse_2", 32'(po), 32'h3);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            si = 1'b1;
            @(posedge clk);
        end
        #1;
        check("saturate_ones", 32'(po), 32'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            si = 1'b0;
            @(posedge clk);
        end
        #1;
        check("flush_zeros", 32'(po), 32'h0);

        @(negedge clk);
        check("b_still_reset", 32'(po_b), 32'hA5);
        reset_b = 1'b0;
        si_b = 1'b1;
        @(posedge clk) #1;
        check("b_first_shift", 32'(po_b), 32'hD2);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            si_b = 1'($urandom);
            si = 1'($urandom);
        end
        @(posedge clk) #2;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
